// File: rtl/unified_mem_arbiter.sv
// ----------------------------------------------------------------------------
// unified_mem_arbiter
//
// Purpose:
//   Shares a single-ported, variable-latency memory between the instruction
//   fetch stage (read-only) and the data stage (load/store). One requester is
//   granted at a time. Data accesses normally win, but a fetch that has waited
//   through STARVE_LIMIT consecutive data grants is forced through. Each
//   completed access returns a one-cycle ready pulse with the read data.
//   A branch flush (if_abort_i) kills the in-flight or pending fetch: the
//   memory transaction still runs to completion, but its result is dropped.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   if_req_i/addr_i     fetch request and PC
//   if_abort_i          branch flush, kills the current/pending fetch
//   if_rdata_o/ready_o  fetched instruction and one-cycle completion pulse
//   dm_read_i/write_i   load / store request (write wins if both are high)
//   dm_addr_i/wdata_i   data address and store data
//   dm_rdata_o/ready_o  load data and one-cycle completion pulse
//   cpu_stall_o         data access outstanding and not completing this cycle
//   mem_req_o/we_o      memory request (held until ack) and write enable
//   mem_addr_o/wdata_o  memory address and write data
//   mem_rdata_i/ack_i   memory read data and completion
//
// FSM states:
//   state | meaning
//   IDLE  | no transaction; grant decision made here
//   FETCH | fetch issued to memory, waiting for ack
//   DATA  | load/store issued to memory, waiting for ack
//   RESP  | ready pulse cycle; no grant, returns to IDLE
// ----------------------------------------------------------------------------
module unified_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_abort_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ready_o,

  input  logic              dm_read_i,
  input  logic              dm_write_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ready_o,

  output logic              cpu_stall_o,

  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  localparam bit FORCE_EN = (STARVE_LIMIT != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              discard_q, discard_d;

  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              if_ready_q, if_ready_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              dm_ready_q, dm_ready_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic              dm_any;
  logic              force_fetch;
  logic              ack_seen;

  assign dm_any      = dm_read_i | dm_write_i;
  // A waiting fetch is forced once it has been passed over STARVE_LIMIT times.
  assign force_fetch = FORCE_EN & if_req_i & (starve_cnt_q == LIMIT);
  // Ack only counts while a request is actually outstanding.
  assign ack_seen    = mem_req_q & mem_ack_i;

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      discard_q    <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_ready_q   <= 1'b0;
      if_rdata_q   <= '0;
      dm_ready_q   <= 1'b0;
      dm_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      discard_q    <= discard_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_ready_q   <= if_ready_d;
      if_rdata_q   <= if_rdata_d;
      dm_ready_q   <= dm_ready_d;
      dm_rdata_q   <= dm_rdata_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    discard_d    = discard_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    // Ready flags are pulses: low unless set on the ack cycle.
    if_ready_d   = 1'b0;
    dm_ready_d   = 1'b0;

    case (state_q)
      IDLE: begin
        discard_d = 1'b0;
        if (dm_any && !force_fetch) begin
          state_d     = DATA;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_write_i;
          mem_addr_d  = dm_addr_i;
          mem_wdata_d = dm_wdata_i;
          if (if_req_i) begin
            if (starve_cnt_q != LIMIT) begin
              starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
          end else begin
            starve_cnt_d = '0;
          end
        end else if (if_req_i && !if_abort_i) begin
          // A flush in the grant cycle simply blocks the fetch grant.
          state_d      = FETCH;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_addr_i;
          starve_cnt_d = '0;
        end
      end

      FETCH: begin
        if (if_abort_i) begin
          discard_d = 1'b1;
        end
        if (ack_seen) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
          // A killed fetch still finishes on the bus but leaves if_rdata_o alone.
          if (!discard_q && !if_abort_i) begin
            if_rdata_d = mem_rdata_i;
            if_ready_d = 1'b1;
          end
        end
      end

      DATA: begin
        if (ack_seen) begin
          mem_req_d  = 1'b0;
          state_d    = RESP;
          dm_ready_d = 1'b1;
          // Stores return no meaningful data; keep the last load result.
          if (!mem_we_q) begin
            dm_rdata_d = mem_rdata_i;
          end
        end
      end

      RESP: begin
        state_d   = IDLE;
        discard_d = 1'b0;
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign dm_ready_o  = dm_ready_q;
  // A flush arriving in the response cycle still has to kill the pulse.
  assign if_ready_o  = if_ready_q & ~if_abort_i;
  assign cpu_stall_o = dm_any & ~dm_ready_q;

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the pipeline's IF stage (instruction fetch, read-only) and MEM stage (load/store).
- Grants one requester at a time and drives a req/ack memory handshake.
- Returns a registered one-cycle ready pulse with read data to the granted requester.
- Supplies the CPU stall condition for outstanding data accesses and drops in-flight fetches killed by a taken-branch flush.

Parameters:
ADDR_W, 32, address width of both requesters and the memory port
DATA_W, 32, data width
STARVE_LIMIT, 4, consecutive data grants allowed while a fetch waits before the fetch is forced; 0 = pure data priority, no forcing

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous, active-high reset
if_req_i  in  1  fetch request, held until if_ready_o or if_abort_i
if_addr_i  in  ADDR_W  fetch address (PC)
if_abort_i  in  1  branch flush; kills the current/pending fetch
if_rdata_o  out  DATA_W  fetched instruction, valid when if_ready_o
if_ready_o  out  1  one-cycle fetch completion pulse
dm_read_i  in  1  load request, held until dm_ready_o
dm_write_i  in  1  store request, held until dm_ready_o
dm_addr_i  in  ADDR_W  data address
dm_wdata_i  in  DATA_W  store data
dm_rdata_o  out  DATA_W  load data, valid when dm_ready_o
dm_ready_o  out  1  one-cycle data completion pulse (loads and stores)
cpu_stall_o  out  1  (dm_read_i|dm_write_i) & ~dm_ready_o, combinational
mem_req_o  out  1  memory request, held until mem_ack_i
mem_we_o  out  1  1 = write
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_rdata_i  in  DATA_W  memory read data, valid with mem_ack_i
mem_ack_i  in  1  memory completion; honoured only while mem_req_o=1

Behaviour:
- Reset
  - State IDLE, starve_cnt=0, discard=0.
  - All registered outputs 0: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, if_ready_o, if_rdata_o, dm_ready_o, dm_rdata_o.
  - Reset mid-transaction abandons it; a later mem_ack_i with mem_req_o=0 is ignored.
- FSM states: IDLE, FETCH, DATA, RESP.
- IDLE grant decision:
  - If dm_read_i|dm_write_i, and not (if_req_i & STARVE_LIMIT!=0 & starve_cnt==STARVE_LIMIT): go to DATA.
  - Else if if_req_i & ~if_abort_i: go to FETCH.
  - Else stay in IDLE.
- On grant (registered, so outputs are visible the next cycle):
  - mem_req_o=1; mem_addr_o, mem_wdata_o and mem_we_o are latched from the winner.
  - mem_we_o = dm_write_i; if dm_read_i and dm_write_i are both high, the write wins.
  - Fetch grants always set mem_we_o=0.
- Starvation counter:
  - On a DATA grant with if_req_i=1: starve_cnt+1, saturating at STARVE_LIMIT.
  - On any FETCH grant: starve_cnt=0.
  - On a DATA grant with if_req_i=0: starve_cnt=0.
- FETCH/DATA:
  - mem_* outputs held stable.
  - On the cycle mem_req_o & mem_ack_i: mem_req_o<=0; read data is captured into if_rdata_o or dm_rdata_o; go to RESP.
  - The requester dropping its request mid-transaction does not cancel it.
- RESP (exactly one cycle):
  - Pulse dm_ready_o=1 for a DATA transaction, or if_ready_o=1 for a FETCH transaction with discard=0.
  - No grant is made in RESP, so a still-asserted request is not re-served.
  - Then go to IDLE and clear discard.
- Abort:
  - if_abort_i=1 during FETCH, or in the IDLE cycle a fetch would be granted, sets discard (or blocks the grant).
  - The memory transaction still completes; if_ready_o stays 0 and if_rdata_o is unchanged.
  - if_abort_i in RESP of a fetch suppresses that cycle's if_ready_o.
  - if_abort_i has no effect on DATA transactions.
- Latency:
  - Minimum request-to-ready is 2 cycles: request seen in IDLE at cycle 0, mem_req_o=1 at cycle 1, ack at cycle 1, ready at cycle 2.
  - Back-to-back grants are separated by RESP, so the best-case throughput is one access per 3 cycles.
- Readiness pulses: if_ready_o and dm_ready_o are never high in the same cycle and are never high for more than one cycle.
- Data output hold: if_rdata_o and dm_rdata_o hold their value until the next capture.

Test Plan:
- Fetch only: if_req_i=1, if_addr_i=0x40, ack on the first mem_req_o cycle, mem_rdata_i=0x8C020004 -> mem_req_o/mem_addr_o=0x40 at cycle 1; if_ready_o=1 and if_rdata_o=0x8C020004 at cycle 2 only; re-grant no earlier than cycle 3.
- Simultaneous requests: if_req_i and dm_read_i (addr 0x10) at cycle 0, ack latency 3 -> data granted first (mem_we_o=0, addr 0x10); dm_ready_o at cycle 4; fetch granted at cycle 5; cpu_stall_o=1 during cycles 0-3 and 0 at cycle 4.
- Store priority: dm_read_i=dm_write_i=1, addr 0x20, wdata 0xDEADBEEF -> mem_we_o=1, mem_wdata_o=0xDEADBEEF; dm_ready_o pulses once.
- Starvation, STARVE_LIMIT=2: if_req_i held, dm requests continuously -> grant order DATA, DATA, FETCH, DATA, ...; starve_cnt returns to 0 after the FETCH grant.
- Abort: if_abort_i pulsed for 1 cycle while FETCH waits for an ack (latency 4) -> transaction completes, if_ready_o never asserts, if_rdata_o unchanged, next IDLE serves the new if_addr_i.
- Reset mid-DATA: rst_i at cycle 2 with mem_req_o=1, then mem_ack_i=1 at cycle 4 -> mem_req_o=0 from cycle 3, no dm_ready_o pulse, all outputs zero, state IDLE.
